// File: rtl/axi_b_arb.sv
//==============================================================================
// axi_b_arb : N-slave to M-master AXI write-response (B) arbiter with a
//             single-entry registered output and a drop path for bad master IDs.
// Optional  : AXI_B_ARB_RR_EN selects round-robin arbitration (default: fixed
//             priority, highest slave index wins).
// Revision  : 1.0
//==============================================================================
`default_nettype none

module axi_b_arb #(
  parameter int NUM_SLAVES  = 5,
  parameter int NUM_MASTERS = 2,
  parameter int ID_BITS     = 4,
  parameter int MASTER_BITS = 4,
  parameter int RESP_BITS   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_SLAVES*(ID_BITS+MASTER_BITS)-1:0] ids_s_i,
  input  logic [NUM_SLAVES*RESP_BITS-1:0]           resp_s_i,
  input  logic [NUM_SLAVES-1:0]                     valid_s_i,
  output logic [NUM_SLAVES-1:0]                     ready_s_o,
  output logic [ID_BITS-1:0]                        id_m_o,
  output logic [RESP_BITS-1:0]                      resp_m_o,
  output logic [NUM_MASTERS-1:0]                    valid_m_o,
  input  logic [NUM_MASTERS-1:0]                    ready_m_i,
  output logic [7:0]                                drop_cnt_o
);

  localparam int IDS_BITS = ID_BITS + MASTER_BITS;
  localparam int PTR_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state;
  logic [IDS_BITS-1:0]   ids_q;
  logic [RESP_BITS-1:0]  resp_q;
  logic [7:0]            drop_cnt;

  logic [MASTER_BITS-1:0] tgt;
  logic                   tgt_ready;
  logic                   full;
  logic                   drain;
  logic                   can_accept;
  logic                   any_valid;
  logic                   accept;

  logic [PTR_BITS-1:0]    grant;
  logic [IDS_BITS-1:0]    ids_sel;
  logic [RESP_BITS-1:0]   resp_sel;
  logic [MASTER_BITS-1:0] new_tgt;
  logic                   new_tgt_ok;

  assign tgt  = ids_q[IDS_BITS-1:ID_BITS];
  assign full = (state == ST_FULL);

  // The stored target is always in range while FULL, so the loop only picks a ready bit.
  always_comb begin
    tgt_ready = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (tgt == MASTER_BITS'(m)) tgt_ready = ready_m_i[m];
    end
  end

  assign drain      = full & tgt_ready;
  assign can_accept = ~full | drain;
  assign any_valid  = |valid_s_i;
  assign accept     = rst & any_valid & can_accept;

`ifdef AXI_B_ARB_RR_EN
  logic [PTR_BITS-1:0]     ptr;
  logic [2*NUM_SLAVES-1:0] dbl_valid;
  logic [NUM_SLAVES-1:0]   rot_valid;
  logic [PTR_BITS:0]       off;
  logic [PTR_BITS:0]       sum;

  localparam logic [PTR_BITS:0] NS_W = (PTR_BITS+1)'(NUM_SLAVES);

  // Rotate so that bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    dbl_valid = {valid_s_i, valid_s_i} >> ptr;
    rot_valid = dbl_valid[NUM_SLAVES-1:0];
    off       = '0;
    for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
      if (rot_valid[j]) off = (PTR_BITS+1)'(j);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NS_W) sum = sum - NS_W;
    grant = sum[PTR_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant == PTR_BITS'(NUM_SLAVES - 1)) ? '0 : grant + 1'b1;
    end
  end
`else
  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (valid_s_i[k]) grant = PTR_BITS'(k);
    end
  end
`endif

  always_comb begin
    ids_sel  = '0;
    resp_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (grant == PTR_BITS'(k)) begin
        ids_sel  = ids_s_i[k*IDS_BITS +: IDS_BITS];
        resp_sel = resp_s_i[k*RESP_BITS +: RESP_BITS];
      end
    end
  end

  assign new_tgt = ids_sel[IDS_BITS-1:ID_BITS];

  always_comb begin
    new_tgt_ok = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (new_tgt == MASTER_BITS'(m)) new_tgt_ok = 1'b1;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < NUM_SLAVES; gk++) begin : g_ready_s
      assign ready_s_o[gk] = accept & (grant == PTR_BITS'(gk));
    end
  endgenerate

  genvar gm;
  generate
    for (gm = 0; gm < NUM_MASTERS; gm++) begin : g_valid_m
      assign valid_m_o[gm] = full & (tgt == MASTER_BITS'(gm));
    end
  endgenerate

  // Responses to a nonexistent master are still handshaken but never presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      ids_q    <= '0;
      resp_q   <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      ids_q  <= ids_sel;
      resp_q <= resp_sel;
      if (new_tgt_ok) begin
        state <= ST_FULL;
      end else begin
        state <= ST_EMPTY;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (drain) begin
      state <= ST_EMPTY;
    end
  end

  assign id_m_o     = ids_q[ID_BITS-1:0];
  assign resp_m_o   = resp_q;
  assign drop_cnt_o = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_b_arb.sv
// Scoreboard bench for axi_b_arb with default parameters (5 slaves, 2 masters).
`default_nettype none

module tb_axi_b_arb;

  logic        clk;
  logic        rst;
  logic [39:0] ids_s;
  logic [9:0]  resp_s;
  logic [4:0]  valid_s;
  logic [4:0]  ready_s;
  logic [3:0]  id_m;
  logic [1:0]  resp_m;
  logic [1:0]  valid_m;
  logic [1:0]  ready_m;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] vm;
    logic [3:0] id;
    logic [1:0] resp;
  } exp_t;

  exp_t exp_q[$];

  axi_b_arb dut (
    .clk        (clk),
    .rst        (rst),
    .ids_s_i    (ids_s),
    .resp_s_i   (resp_s),
    .valid_s_i  (valid_s),
    .ready_s_o  (ready_s),
    .id_m_o     (id_m),
    .resp_m_o   (resp_m),
    .valid_m_o  (valid_m),
    .ready_m_i  (ready_m),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input int k, input logic [7:0] ids, input logic [1:0] resp,
                           input logic v);
    ids_s[k*8 +: 8]  = ids;
    resp_s[k*2 +: 2] = resp;
    valid_s[k]       = v;
  endtask

  task automatic push(input logic [1:0] vm, input logic [3:0] id, input logic [1:0] resp);
    exp_t e;
    e.vm   = vm;
    e.id   = id;
    e.resp = resp;
    exp_q.push_back(e);
  endtask

  // Monitor: every master-side handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_s_onehot", {31'd0, $onehot0(ready_s)}, 32'd1);
      if ((valid_m & ready_m) != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_b actual=vm%0h/id%0h/resp%0h required=none",
                   valid_m, id_m, resp_m);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("b_valid_m", {30'd0, valid_m}, {30'd0, e.vm});
          chk("b_id",      {28'd0, id_m},    {28'd0, e.id});
          chk("b_resp",    {30'd0, resp_m},  {30'd0, e.resp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int         g_exp[6];
  logic [4:0] vpat;

  initial begin
    rst     = 1'b0;
    ids_s   = '0;
    resp_s  = '0;
    valid_s = '0;
    ready_m = 2'b11;

    // Reset state, with a slave valid that must not be readied
    set_slave(1, 8'h13, 2'b00, 1'b1);
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready_s", {27'd0, ready_s}, 32'd0);
    chk("rst_valid_m", {30'd0, valid_m}, 32'd0);
    chk("rst_id_m",    {28'd0, id_m},    32'd0);
    chk("rst_resp_m",  {30'd0, resp_m},  32'd0);
    chk("rst_drop",    {24'd0, drop_cnt}, 32'd0);
    step();
    valid_s = '0;
    rst     = 1'b1;
    step();

    // Single response
    set_slave(1, 8'h13, 2'b00, 1'b1);
    push(2'b10, 4'h3, 2'b00);
    @(negedge clk);
    chk("single_ready_s", {27'd0, ready_s}, 32'h02);
    step();
    valid_s = '0;
    @(negedge clk);
    chk("single_valid_m", {30'd0, valid_m}, 32'h2);
    chk("single_id_m",    {28'd0, id_m},    32'h3);
    step();
    @(negedge clk);
    chk("single_empty", {30'd0, valid_m}, 32'h0);

    // Backpressure on master 0
    step();
    ready_m = 2'b10;
    set_slave(0, 8'h05, 2'b01, 1'b1);
    push(2'b01, 4'h5, 2'b01);
    @(negedge clk);
    chk("bp_ready_first", {27'd0, ready_s}, 32'h01);
    step();
    set_slave(0, 8'h07, 2'b10, 1'b1);
    push(2'b01, 4'h7, 2'b10);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_valid", {30'd0, valid_m}, 32'h1);
      chk("bp_stall_id",    {28'd0, id_m},    32'h5);
      chk("bp_stall_ready", {27'd0, ready_s}, 32'h00);
      if (i < 2) begin
        step();
        @(negedge clk);
      end
    end
    step();
    ready_m = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", {27'd0, ready_s}, 32'h01);
    step();
    valid_s = '0;
    @(negedge clk);
    chk("bp_second_id", {28'd0, id_m}, 32'h7);
    step();
    @(negedge clk);
    chk("bp_empty", {30'd0, valid_m}, 32'h0);

    // Simultaneous drain and accept
    step();
    ready_m = 2'b00;
    set_slave(1, 8'h1A, 2'b10, 1'b1);
    push(2'b10, 4'hA, 2'b10);
    @(negedge clk);
    chk("da_first_ready", {27'd0, ready_s}, 32'h02);
    step();
    valid_s = '0;
    ready_m = 2'b10;
    set_slave(3, 8'h0B, 2'b01, 1'b1);
    push(2'b01, 4'hB, 2'b01);
    @(negedge clk);
    chk("da_ready_s", {27'd0, ready_s}, 32'h08);
    chk("da_valid_m", {30'd0, valid_m}, 32'h2);
    step();
    valid_s = '0;
    ready_m = 2'b11;
    @(negedge clk);
    chk("da_next_valid_m", {30'd0, valid_m}, 32'h1);
    chk("da_next_id",      {28'd0, id_m},    32'hB);
    step();

    // Drop path and counter saturation
    set_slave(2, 8'h31, 2'b00, 1'b1);
    @(negedge clk);
    chk("drop_ready_s", {27'd0, ready_s}, 32'h04);
    chk("drop_valid_m", {30'd0, valid_m}, 32'h0);
    step();
    valid_s = '0;
    @(negedge clk);
    chk("drop_cnt_1",      {24'd0, drop_cnt}, 32'd1);
    chk("drop_valid_m_1",  {30'd0, valid_m},  32'h0);
    step();
    valid_s[2] = 1'b1;
    repeat (253) @(posedge clk);
    #1;
    valid_s = '0;
    @(negedge clk);
    chk("drop_cnt_254", {24'd0, drop_cnt}, 32'd254);
    step();
    valid_s[2] = 1'b1;
    repeat (46) @(posedge clk);
    #1;
    valid_s = '0;
    @(negedge clk);
    chk("drop_cnt_sat",   {24'd0, drop_cnt}, 32'd255);
    chk("drop_valid_sat", {30'd0, valid_m},  32'h0);

    // Reset while FULL
    step();
    ready_m = 2'b00;
    set_slave(0, 8'h0D, 2'b11, 1'b1);
    @(negedge clk);
    chk("rm_accept_ready", {27'd0, ready_s}, 32'h01);
    step();
    rst = 1'b0;
    set_slave(0, 8'h0E, 2'b11, 1'b1);
    @(negedge clk);
    chk("rm_ready_in_rst", {27'd0, ready_s}, 32'h00);
    step();
    @(negedge clk);
    chk("rm_valid_m", {30'd0, valid_m},  32'h0);
    chk("rm_drop",    {24'd0, drop_cnt}, 32'd0);
    chk("rm_ready_s", {27'd0, ready_s},  32'h00);
    chk("rm_id_m",    {28'd0, id_m},     32'h0);
    step();
    valid_s = '0;
    rst     = 1'b1;
    @(negedge clk);
    chk("rm_after_valid_m", {30'd0, valid_m}, 32'h0);

    // Contention among slaves 0, 2, 4 (slave 4 drops out after three cycles)
`ifdef AXI_B_ARB_RR_EN
    g_exp = '{0, 2, 4, 0, 2, 0};
`else
    g_exp = '{4, 4, 4, 2, 2, 2};
`endif
    ready_m = 2'b11;
    set_slave(0, 8'h08, 2'b01, 1'b0);
    set_slave(2, 8'h0A, 2'b11, 1'b0);
    set_slave(4, 8'h0C, 2'b01, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      valid_s = (c < 3) ? 5'b10101 : 5'b00101;
      push(2'b01, 4'(g_exp[c] + 8), 2'((g_exp[c] + 1) % 4));
      vpat = 5'b00001 << g_exp[c];
      @(negedge clk);
      chk("cont_grant", {27'd0, ready_s}, {27'd0, vpat});
    end
    step();
    valid_s = '0;
    step();
    @(negedge clk);
    chk("cont_empty", {30'd0, valid_m}, 32'h0);

    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_b_arb.md
Name: axi_b_arb

Overview:
- Parametrised write-response (B) channel interconnect: N slaves' B channels into M masters' B channels.
- Arbitrates among concurrently valid slaves and captures the winner into a single-entry output register.
- Routes each response to the master encoded in the upper bits of its extended ID.
- Successor to the fixed 5-slave / 1-master combinational B mux. Adds arbitration for simultaneous valids, multi-master routing, registered output with full throughput, and a drop path for invalid master IDs.

Parameters:
- NUM_SLAVES, 5, number of slave B ports (index NUM_SLAVES-1 is the default slave).
- NUM_MASTERS, 2, number of master B ports.
- ID_BITS, 4, master-side ID width.
- MASTER_BITS, 4, master-select field width; slave-side IDS width = ID_BITS+MASTER_BITS.
- RESP_BITS, 2, BRESP width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- ids_s_i  in  NUM_SLAVES*(ID_BITS+MASTER_BITS)  per-slave BID; slave k occupies slice k.
- resp_s_i  in  NUM_SLAVES*RESP_BITS  per-slave BRESP.
- valid_s_i  in  NUM_SLAVES  per-slave BVALID.
- ready_s_o  out  NUM_SLAVES  per-slave BREADY; at most one bit high.
- id_m_o  out  ID_BITS  BID, shared by all masters.
- resp_m_o  out  RESP_BITS  BRESP, shared by all masters.
- valid_m_o  out  NUM_MASTERS  per-master BVALID; at most one bit high.
- ready_m_i  in  NUM_MASTERS  per-master BREADY.
- drop_cnt_o  out  8  count of dropped responses; saturates at 255.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Output register empty; valid_m_o=0, id_m_o=0, resp_m_o=0, drop_cnt_o=0.
  - Round-robin pointer=0.
  - ready_s_o=0 while rst==0.
- Output register: state EMPTY or FULL. Holds ids, resp, and tgt = ids[ID_BITS+MASTER_BITS-1:ID_BITS].
- Drain condition: drain = FULL & ready_m_i[tgt].
- Accept condition: can_accept = EMPTY | drain.
- Arbitration is combinational each cycle over valid_s_i. Grant g is chosen per policy (see Optional Feature).
- ready_s_o[g] = can_accept & valid_s_i[g]. All other ready_s_o bits are 0, and ready_s_o is 0 when no slave is valid.
- Accept (handshake on slave g):
  - Register loads ids_s_i[g] and resp_s_i[g].
  - tgt < NUM_MASTERS: next state FULL.
  - tgt >= NUM_MASTERS: response is sunk, state becomes/stays EMPTY, drop_cnt_o increments (saturating).
- valid_m_o[tgt] = FULL & (tgt < NUM_MASTERS). id_m_o = stored ids[ID_BITS-1:0]. resp_m_o = stored resp.
- Drain with no accept in the same cycle: FULL -> EMPTY. Drain and accept in the same cycle: stays FULL with the new data (back-to-back, 1 response/cycle).
- Latency: slave handshake at cycle T gives valid_m_o at T+1.
- Output stability: while FULL and not drained, id_m_o, resp_m_o and valid_m_o are held stable (AXI).
- A slave whose valid is not granted keeps valid; no ready is issued to it.
- Reset mid-transfer: a pending FULL entry is discarded and no ready is issued. Slaves re-present their responses after reset.

Optional Feature:
- Macro: AXI_B_ARB_RR_EN.
- Defined:
  - Round-robin. Search starts at the pointer and wraps modulo NUM_SLAVES; the first valid index wins.
  - On accept, pointer <= (g+1) mod NUM_SLAVES. Pointer is unchanged without an accept.
- Undefined:
  - Fixed priority; highest index wins (default slave first, slave 0 last).
  - No pointer register.

Test Plan:
- Single response: slave 1 valid, ids=8'h13, resp=2'b00, ready_m_i=2'b11 -> ready_s_o=5'b00010 in T; valid_m_o=2'b10, id_m_o=4'h3, resp_m_o=0 in T+1; EMPTY in T+2.
- Backpressure: slave 0 sends ids=8'h05 then ids=8'h07, ready_m_i[0]=0 for 3 cycles -> valid_m_o[0] stays high with id 5 held, ready_s_o[0]=0 during the stall; after release id 5 then id 7 on consecutive cycles.
- Contention, RR on: slaves 0, 2, 4 valid continuously to master 0, ready_m_i=1 -> grant order 0,2,4,0,2,4, one per cycle. RR off -> 4,4,... until slave 4 drops valid.
- Drop: slave 2 ids=8'h31 with NUM_MASTERS=2 -> ready_s_o[2] asserted, valid_m_o stays 0, drop_cnt_o 0->1. 300 such responses -> drop_cnt_o=255.
- Simultaneous drain+accept: FULL to master 1, ready_m_i[1]=1, slave 3 valid to master 0 -> next cycle valid_m_o=2'b01 with slave 3 data, no bubble.
- Reset mid-op: rst=0 while FULL -> next cycle valid_m_o=0, drop_cnt_o=0, ready_s_o=0 for all cycles with rst=0.
